// File: rtl/usb_packet_tx.sv
// FT245 packet transmitter: writes a header, the streamed payload and a trailer
// through a byte writer that handles the FT_TXEn/FT_WR handshake.
module usb_packet_tx #(
  parameter logic [7:0] HEADER_KEY_SYMBOL         = 8'h55,
  parameter int         HEADER_KEY_SYMBOL_NUMBER  = 12,
  parameter logic [7:0] TRAILER_KEY_SYMBOL        = 8'hAA,
  parameter int         TRAILER_KEY_SYMBOL_NUMBER = 8,
  parameter logic [7:0] ERROR_SYMBOL              = 8'hEE,
  parameter int         WR_CYCLES                 = 3,
  parameter int         BLANK_CYCLES              = 4,
  parameter int         STALL_TIMEOUT             = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Start,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_Valid,
  input  logic       Tx_Last,
  output logic       Tx_Ready,
  input  logic       FT_TXEn,
  output logic       FT_WR,
  output logic [7:0] FT_DATA_Out,
  output logic       FT_OE,
  output logic       Busy,
  output logic       Done,
  output logic       Error
);

  localparam int MAX_SYM = (HEADER_KEY_SYMBOL_NUMBER > TRAILER_KEY_SYMBOL_NUMBER) ?
                           HEADER_KEY_SYMBOL_NUMBER : TRAILER_KEY_SYMBOL_NUMBER;
  localparam int CW      = $clog2(MAX_SYM + 1);
  localparam int TMAX_A  = (STALL_TIMEOUT > WR_CYCLES) ? STALL_TIMEOUT : WR_CYCLES;
  localparam int TMAX    = (TMAX_A > BLANK_CYCLES) ? TMAX_A : BLANK_CYCLES;
  localparam int TW      = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, ERR, TRAILER} pkt_t;
  typedef enum logic [2:0] {FETCH, WAIT_TXE, SETUP, STROBE, HOLD, BLANK} sub_t;

  pkt_t          pkt_q, pkt_nxt;
  sub_t          sub_q, sub_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic [TW-1:0] tmr_q, tmr_nxt;
  logic [7:0]    data_q, pay_q, sym;
  logic          last_q, load, accept, last_sym;
  logic          busy_q, busy_nxt, error_q, error_nxt, done_q, done_nxt;
  logic          ft_wr_q, ft_oe_q;
  logic          txe_s1, txe_s2;

  always_comb begin
    case (pkt_q)
      PAYLOAD: sym = pay_q;
      ERR:     sym = ERROR_SYMBOL;
      TRAILER: sym = TRAILER_KEY_SYMBOL;
      default: sym = HEADER_KEY_SYMBOL;
    endcase
  end

  assign last_sym = (pkt_q == TRAILER) ? (cnt_q == CW'(TRAILER_KEY_SYMBOL_NUMBER - 1))
                                       : (cnt_q == CW'(HEADER_KEY_SYMBOL_NUMBER - 1));

  always_comb begin
    pkt_nxt   = pkt_q;
    sub_nxt   = sub_q;
    cnt_nxt   = cnt_q;
    tmr_nxt   = tmr_q;
    load      = 1'b0;
    accept    = 1'b0;
    busy_nxt  = busy_q;
    error_nxt = error_q;
    done_nxt  = 1'b0;
    if (pkt_q == IDLE) begin
      sub_nxt = FETCH;
      if (Start) begin
        pkt_nxt   = HEADER;
        sub_nxt   = WAIT_TXE;
        cnt_nxt   = '0;
        busy_nxt  = 1'b1;
        error_nxt = 1'b0;
      end
    end else begin
      case (sub_q)
        FETCH: begin
          if (Tx_Valid) begin
            accept  = 1'b1;
            sub_nxt = WAIT_TXE;
          end else if (tmr_q == '0) begin
            pkt_nxt   = ERR;
            sub_nxt   = WAIT_TXE;
            error_nxt = 1'b1;
          end else begin
            tmr_nxt = tmr_q - TW'(1);
          end
        end
        WAIT_TXE: begin
          if (!txe_s2) begin
            sub_nxt = SETUP;
            load    = 1'b1;
          end
        end
        SETUP: begin
          sub_nxt = STROBE;
          tmr_nxt = TW'(WR_CYCLES - 1);
        end
        STROBE: begin
          if (tmr_q == '0) sub_nxt = HOLD;
          else             tmr_nxt = tmr_q - TW'(1);
        end
        HOLD: begin
          sub_nxt = BLANK;
          tmr_nxt = TW'(BLANK_CYCLES - 1);
        end
        BLANK: begin
          if (tmr_q != '0) begin
            tmr_nxt = tmr_q - TW'(1);
          end else begin
            // byte finished: pick what the writer sends next
            case (pkt_q)
              HEADER: begin
                if (last_sym) begin
                  pkt_nxt = PAYLOAD;
                  sub_nxt = FETCH;
                  cnt_nxt = '0;
                  tmr_nxt = TW'(STALL_TIMEOUT - 1);
                end else begin
                  cnt_nxt = cnt_q + CW'(1);
                  sub_nxt = WAIT_TXE;
                end
              end
              PAYLOAD: begin
                if (last_q) begin
                  pkt_nxt = TRAILER;
                  sub_nxt = WAIT_TXE;
                  cnt_nxt = '0;
                end else begin
                  sub_nxt = FETCH;
                  tmr_nxt = TW'(STALL_TIMEOUT - 1);
                end
              end
              ERR: begin
                pkt_nxt = TRAILER;
                sub_nxt = WAIT_TXE;
                cnt_nxt = '0;
              end
              TRAILER: begin
                if (last_sym) begin
                  pkt_nxt  = IDLE;
                  sub_nxt  = FETCH;
                  done_nxt = 1'b1;
                  busy_nxt = 1'b0;
                end else begin
                  cnt_nxt = cnt_q + CW'(1);
                  sub_nxt = WAIT_TXE;
                end
              end
              default: begin
                pkt_nxt = IDLE;
                sub_nxt = FETCH;
              end
            endcase
          end
        end
        default: begin
          pkt_nxt = IDLE;
          sub_nxt = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q   <= IDLE;
      sub_q   <= FETCH;
      cnt_q   <= '0;
      tmr_q   <= '0;
      data_q  <= '0;
      pay_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
      ft_wr_q <= 1'b0;
      ft_oe_q <= 1'b0;
      txe_s1  <= 1'b1;
      txe_s2  <= 1'b1;
    end else begin
      pkt_q   <= pkt_nxt;
      sub_q   <= sub_nxt;
      cnt_q   <= cnt_nxt;
      tmr_q   <= tmr_nxt;
      busy_q  <= busy_nxt;
      error_q <= error_nxt;
      done_q  <= done_nxt;
      txe_s1  <= FT_TXEn;
      txe_s2  <= txe_s1;
      if (load) data_q <= sym;
      if (accept) begin
        pay_q  <= Tx_Data;
        last_q <= Tx_Last;
      end
      // strobe/enable registered from next state so the pins are glitch-free
      ft_wr_q <= (sub_nxt == STROBE);
      ft_oe_q <= (sub_nxt == SETUP) || (sub_nxt == STROBE) || (sub_nxt == HOLD);
    end
  end

  assign Tx_Ready    = (pkt_q == PAYLOAD) && (sub_q == FETCH);
  assign FT_WR       = ft_wr_q;
  assign FT_OE       = ft_oe_q;
  assign FT_DATA_Out = data_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Error       = error_q;

endmodule

// File: tb/tb_usb_packet_tx.sv
// Directed bench for usb_packet_tx: byte stream, handshake timing, stall,
// ignored requests and asynchronous reset.
module tb_usb_packet_tx;

  logic       clk, rst_n, start, tx_valid, tx_last, ft_txen;
  logic [7:0] tx_data;
  logic       tx_ready, ft_wr, ft_oe, busy, done, error;
  logic [7:0] ft_data;

  int total = 0;
  int bad   = 0;

  usb_packet_tx dut (
    .clk(clk), .rst_n(rst_n), .Start(start), .Tx_Data(tx_data), .Tx_Valid(tx_valid),
    .Tx_Last(tx_last), .Tx_Ready(tx_ready), .FT_TXEn(ft_txen), .FT_WR(ft_wr),
    .FT_DATA_Out(ft_data), .FT_OE(ft_oe), .Busy(busy), .Done(done), .Error(error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // bus monitor, sampled on the falling clock edge
  logic [7:0] caught[$];
  logic [7:0] exp_q[$];
  logic [7:0] pay[$];
  int   wr_run = 0, width_bad = 0, stab_bad = 0, rise_cnt = 0, done_cnt = 0;
  logic wr_prev = 1'b0, oe_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  always @(negedge clk) begin
    if (ft_wr) wr_run++;
    if (wr_prev && !ft_wr) begin
      caught.push_back(ft_data);
      if (wr_run != 3) width_bad++;
      wr_run = 0;
    end
    if (!wr_prev && ft_wr) rise_cnt++;
    if (ft_oe && oe_prev && ft_data !== data_prev) stab_bad++;
    if (done) done_cnt++;
    wr_prev   = ft_wr;
    oe_prev   = ft_oe;
    data_prev = ft_data;
  end

  function automatic void build_exp(input int npay, input bit err);
    exp_q.delete();
    repeat (12) exp_q.push_back(8'h55);
    for (int i = 0; i < npay; i++) exp_q.push_back(pay[i]);
    if (err) exp_q.push_back(8'hEE);
    repeat (8) exp_q.push_back(8'hAA);
  endfunction

  task automatic clear_mon();
    caught.delete();
    done_cnt = 0;
  endtask

  task automatic start_pkt();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_payload(input int n_send);
    bit got;
    int guard;
    for (int i = 0; i < n_send; i++) begin
      tx_data  = pay[i];
      tx_last  = (i == pay.size() - 1);
      tx_valid = 1'b1;
      got = 1'b0;
      guard = 0;
      while (!got && guard < 3000) begin
        @(negedge clk);
        if (tx_ready) got = 1'b1;
        @(posedge clk);
        guard++;
      end
      #1;
      if (!got) begin
        bad++;
        $display("FAIL payload_accept byte=%0d not taken within %0d cycles", i, guard);
      end
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < limit) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({ft_wr, ft_oe, tx_ready, busy, done, error} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=000000", {ft_wr, ft_oe, tx_ready, busy, done, error});
    end
    total++;
    if (ft_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_data got=%h want=00", ft_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    bit ok;
    pay = '{8'h00, 8'hFF, 8'hAB, 8'h10};
    clear_mon();
    start_pkt();
    fork
      send_payload(4);
      wait_done(2000, cyc, ok);
    join
    total++;
    if (!ok) begin bad++; $display("FAIL basic_done got=timeout want=pulse"); end
    // 12x10 header + 4x11 payload + 8x10 trailer
    total++;
    if (cyc != 244) begin bad++; $display("FAIL basic_cycles got=%0d want=244", cyc); end
    total++;
    if (busy !== 1'b0 || error !== 1'b0) begin
      bad++;
      $display("FAIL basic_flags busy=%b error=%b want busy=0 error=0", busy, error);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", done_cnt); end
    build_exp(4, 1'b0);
    total++;
    if (caught.size() != exp_q.size()) begin
      bad++;
      $display("FAIL basic_len got=%0d want=%0d", caught.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < caught.size(); i++) begin
      total++;
      if (caught[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL basic_byte%0d got=%h want=%h", i, caught[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_ignore();
    int cyc;
    bit ok;
    tx_valid = 1'b1;
    tx_data  = 8'h77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (tx_ready !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_ready cycle=%0d ready=%b busy=%b want 0 0", i, tx_ready, busy);
      end
    end
    tx_valid = 1'b0;
    pay = '{8'h5C};
    clear_mon();
    start_pkt();
    fork
      send_payload(1);
      wait_done(2000, cyc, ok);
      begin
        repeat (30) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (150) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    total++;
    if (!ok || cyc != 211) begin
      bad++;
      $display("FAIL ignore_cycles got=%0d ok=%0d want=211", cyc, ok);
    end
    repeat (3) @(posedge clk);
    #1;
    build_exp(1, 1'b0);
    total++;
    if (caught.size() != exp_q.size()) begin
      bad++;
      $display("FAIL ignore_len got=%0d want=%0d", caught.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < caught.size(); i++) begin
      total++;
      if (caught[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL ignore_byte%0d got=%h want=%h", i, caught[i], exp_q[i]);
      end
    end
    total++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_done got=%0d busy=%b want=1 busy=0", done_cnt, busy);
    end
  endtask

  task automatic test_txe_block();
    int cyc, n, r0, g;
    bit ok;
    pay = '{8'h3C, 8'hC3, 8'h01};
    clear_mon();
    start_pkt();
    fork
      send_payload(3);
      wait_done(3000, cyc, ok);
      begin
        g = 0;
        while (caught.size() < 4 && g < 200) begin
          @(posedge clk);
          g++;
        end
        #1 ft_txen = 1'b1;
        r0 = rise_cnt;
        repeat (50) @(posedge clk);
        #1;
        total++;
        if (rise_cnt != r0) begin
          bad++;
          $display("FAIL txe_blocked rises=%0d want=0", rise_cnt - r0);
        end
        ft_txen = 1'b0;
        n = 0;
        while (rise_cnt == r0 && n < 20) begin
          @(posedge clk);
          n++;
          @(negedge clk);
          #1;
        end
        // two sync flops, WAIT_TXE exit, SETUP
        total++;
        if (n < 2 || n > 4) begin
          bad++;
          $display("FAIL txe_release latency=%0d want 2..4", n);
        end
      end
    join
    total++;
    if (!ok) begin bad++; $display("FAIL txe_done got=timeout want=pulse"); end
    repeat (3) @(posedge clk);
    #1;
    build_exp(3, 1'b0);
    total++;
    if (caught.size() != exp_q.size()) begin
      bad++;
      $display("FAIL txe_len got=%0d want=%0d", caught.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < caught.size(); i++) begin
      total++;
      if (caught[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL txe_byte%0d got=%h want=%h", i, caught[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_stall();
    int cyc;
    bit ok;
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_mon();
    start_pkt();
    fork
      send_payload(2);
      wait_done(3000, cyc, ok);
    join
    // 120 header + 22 payload + 1024 stall + 10 error byte + 80 trailer
    total++;
    if (!ok || cyc != 1256) begin
      bad++;
      $display("FAIL stall_cycles got=%0d ok=%0d want=1256", cyc, ok);
    end
    total++;
    if (error !== 1'b1) begin bad++; $display("FAIL stall_error got=%b want=1", error); end
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (error !== 1'b1) begin bad++; $display("FAIL stall_sticky got=%b want=1", error); end
    build_exp(2, 1'b1);
    total++;
    if (caught.size() != exp_q.size()) begin
      bad++;
      $display("FAIL stall_len got=%0d want=%0d", caught.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < caught.size(); i++) begin
      total++;
      if (caught[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL stall_byte%0d got=%h want=%h", i, caught[i], exp_q[i]);
      end
    end
    pay = '{8'h99};
    start_pkt();
    total++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL stall_clear error=%b busy=%b want error=0 busy=1", error, busy);
    end
    fork
      send_payload(1);
      wait_done(2000, cyc, ok);
    join
    total++;
    if (!ok || error !== 1'b0) begin
      bad++;
      $display("FAIL stall_recover ok=%0d error=%b want ok=1 error=0", ok, error);
    end
  endtask

  task automatic test_timing();
    total++;
    if (width_bad != 0) begin bad++; $display("FAIL wr_width bad_strobes=%0d want=0", width_bad); end
    total++;
    if (stab_bad != 0) begin bad++; $display("FAIL data_stable changes=%0d want=0", stab_bad); end
  endtask

  task automatic test_async_reset();
    int cyc, r0, g;
    bit ok;
    clear_mon();
    r0 = rise_cnt;
    start_pkt();
    g = 0;
    while (rise_cnt < r0 + 5 && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (ft_wr !== 1'b0 || ft_oe !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset wr=%b oe=%b busy=%b want 0 0 0", ft_wr, ft_oe, busy);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_mon();
    width_bad = 0;
    stab_bad  = 0;
    wr_run    = 0;
    pay = '{8'h7E};
    start_pkt();
    fork
      send_payload(1);
      wait_done(2000, cyc, ok);
    join
    total++;
    if (!ok) begin bad++; $display("FAIL rst_done got=timeout want=pulse"); end
    repeat (3) @(posedge clk);
    #1;
    build_exp(1, 1'b0);
    total++;
    if (caught.size() != 21) begin
      bad++;
      $display("FAIL rst_len got=%0d want=21", caught.size());
    end
    for (int i = 0; i < exp_q.size() && i < caught.size(); i++) begin
      total++;
      if (caught[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rst_byte%0d got=%h want=%h", i, caught[i], exp_q[i]);
      end
    end
    total++;
    if (width_bad != 0 || stab_bad != 0) begin
      bad++;
      $display("FAIL rst_timing width_bad=%0d stab_bad=%0d want 0 0", width_bad, stab_bad);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = 8'h00;
    ft_txen  = 1'b0;
    test_reset();
    test_basic();
    test_ignore();
    test_txe_block();
    test_stall();
    test_timing();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
